uart_rx: RTL



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_sync2.sv | 28 ++
 rtl/uart_rx.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: encodings and timing constants shared by the UART RX and TX stages.
package uart_pkg;

    // Line-protocol FSM states; encodings are fixed so both stages agree.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } uart_state_e;

    // Oversampling ratio of baud_tick relative to the bit rate.
    localparam int unsigned OVERSAMPLE    = 16;
    // Width of the per-bit tick counter (counts 0..OVERSAMPLE-1).
    localparam int unsigned TICK_W        = 4;
    // Single-sample point within a bit.
    localparam int unsigned SAMPLE_TICK   = 7;
    // Last of the three majority-vote samples; the vote is decided here.
    localparam int unsigned MAJ_LAST_TICK = 8;

    // 2-of-3 majority vote.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for asynchronous single-bit inputs.
// ResetVal sets the level both flops take in reset (idle level of the input).
module uart_sync2 #(
    parameter logic ResetVal = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input; meta_q may go metastable.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: serial receiver, 1 start, DataBits data (LSB first), 1 stop, no parity.
// Oversampled 16x by the shared baud_tick. Outputs a one-cycle rx_valid per good
// frame and a one-cycle frame_err when the stop bit is low.
// Build option: define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote
// over tick_cnt 6, 7 and 8 instead of a single sample at tick_cnt 7.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DataBits = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                baud_tick,
    input  logic                rx,
    output logic [DataBits-1:0] rx_data,
    output logic                rx_valid,
    output logic                frame_err,
    output logic                rx_busy
);

    localparam int unsigned         BitIdxW    = (DataBits > 1) ? $clog2(DataBits) : 1;
    localparam logic [TICK_W-1:0]   TickLast   = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BitIdxW-1:0]  BitIdxLast = BitIdxW'(DataBits - 1);

    logic                rx_s;

    uart_state_e         state_q,     state_d;
    logic [TICK_W-1:0]   tick_cnt_q,  tick_cnt_d;
    logic [BitIdxW-1:0]  bit_idx_q,   bit_idx_d;
    logic [DataBits-1:0] shift_q,     shift_d;
    logic                armed_q,     armed_d;
    logic [DataBits-1:0] rx_data_q,   rx_data_d;
    logic                rx_valid_q,  rx_valid_d;
    logic                frame_err_q, frame_err_d;

    // Decision strobe for the current bit and the bit value decided there.
    logic                sample_pt;
    logic                bit_val;
    logic                tick_last;

    uart_sync2 #(
        .ResetVal (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    assign tick_last = (tick_cnt_q == TickLast);

`ifdef UART_RX_MAJORITY_EN
    logic early_q;
    logic mid_q;

    // Capture the two samples ahead of the decision tick for the vote.
    always_ff @(posedge clk) begin
        if (rst) begin
            early_q <= 1'b1;
            mid_q   <= 1'b1;
        end else if (baud_tick) begin
            if (tick_cnt_q == TICK_W'(SAMPLE_TICK - 1)) begin
                early_q <= rx_s;
            end
            if (tick_cnt_q == TICK_W'(SAMPLE_TICK)) begin
                mid_q <= rx_s;
            end
        end
    end

    assign sample_pt = baud_tick && (tick_cnt_q == TICK_W'(MAJ_LAST_TICK));
    assign bit_val   = maj3(early_q, mid_q, rx_s);
`else
    assign sample_pt = baud_tick && (tick_cnt_q == TICK_W'(SAMPLE_TICK));
    assign bit_val   = rx_s;
`endif

    // State and datapath registers; reset drops any partial frame silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            tick_cnt_q  <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            armed_q     <= 1'b1;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            armed_q     <= armed_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state logic: everything advances only on baud_tick.
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        armed_d     = armed_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (baud_tick) begin
                    if (rx_s) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d    = StStart;
                        tick_cnt_d = '0;
                    end
                end
            end

            StStart: begin
                if (baud_tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (sample_pt && bit_val) begin
                        // Line back high at mid-bit: glitch, not a start bit.
                        state_d = StIdle;
                    end else if (tick_last) begin
                        state_d    = StData;
                        tick_cnt_d = '0;
                        bit_idx_d  = '0;
                    end
                end
            end

            StData: begin
                if (baud_tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (sample_pt) begin
                        // LSB arrives first, so shifting right leaves it at bit 0.
                        shift_d                = shift_q >> 1;
                        shift_d[DataBits-1]    = bit_val;
                    end
                    if (tick_last) begin
                        tick_cnt_d = '0;
                        if (bit_idx_q == BitIdxLast) begin
                            state_d = StStop;
                        end else begin
                            bit_idx_d = bit_idx_q + BitIdxW'(1);
                        end
                    end
                end
            end

            StStop: begin
                if (baud_tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    // Decide at mid-stop and leave at once so a back-to-back
                    // start edge is not missed.
                    if (sample_pt) begin
                        state_d = StIdle;
                        if (bit_val) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            // Low stop: possibly a break; wait for idle-high to re-arm.
                            frame_err_d = 1'b1;
                            armed_d     = 1'b0;
                        end
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = (state_q != StIdle);

endmodule
